// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready pipeline register with a 2-entry skid buffer, flush and a saturating stall counter
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic                   r_out_valid, r_skid_valid;
  logic [DATA_W-1:0]      r_head_data, r_skid_data;
  logic [CTRL_W-1:0]      r_head_ctrl, r_skid_ctrl;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_accept, w_take, w_stall;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_take    = r_out_valid & out_ready;
  assign w_stall   = r_out_valid & ~out_ready & ~Flush & ~&r_stall_cnt;
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_out_valid;
  assign out_data  = r_head_data;
  assign out_ctrl  = r_out_valid ? r_head_ctrl : BUBBLE_CTRL;
  assign occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
  assign stall_cnt = r_stall_cnt;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_head_data  <= '0;
      r_head_ctrl  <= BUBBLE_CTRL;
      r_skid_data  <= '0;
      r_skid_ctrl  <= BUBBLE_CTRL;
    end else if (Flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_head_ctrl  <= BUBBLE_CTRL;
    end else if (!r_out_valid || w_take) begin
      // head slot is free this cycle: refill from skid first to keep FIFO order
      r_out_valid  <= r_skid_valid | w_accept;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) begin
        r_head_data <= r_skid_data;
        r_head_ctrl <= r_skid_ctrl;
      end else if (w_accept) begin
        r_head_data <= in_data;
        r_head_ctrl <= in_ctrl;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
      r_skid_ctrl  <= in_ctrl;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
endmodule
